// File: rtl/wta_pkg.sv
// Shared constants and result record for the winner-take-all arbiter.
// Imported by every file of the wta block.
package wta_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int NIB_W  = 4;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              upper;
    } wta_res_t;

endpackage

// File: rtl/wta_rr_arb.sv
// Round-robin grant: first set request at or above ptr, modulo N_REQ.
// Ports: req (request vector), ptr (priority pointer), en (grant enable),
//        gnt (one-hot grant, zero when disabled), gnt_idx (encoded winner).
module wta_rr_arb
    import wta_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // index arithmetic wraps naturally at ID_W bits
            idx = ptr + ID_W'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wta_arbiter.sv
// Four requesters share one two-stage winner-take-all nibble datapath.
// Ports: clk, rst (async high); req_valid/req_data/req_ready per requester;
//        out_valid/out_ready/out_data/out_id/out_upper result; busy.
module wta_arbiter
    import wta_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_upper,
    output logic                    busy
);

    logic [ID_W-1:0]   ptr;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [ID_W-1:0]   s1_id;
    wta_res_t          s2_q;
    wta_res_t          s2_d;
    logic              s2_ready;
    logic              s1_load_ok;
    logic              accept;
    logic [ID_W-1:0]   gnt_idx;
    logic [DATA_W-1:0] gnt_data;

    // stage 2 takes a word when empty or draining this cycle
    assign s2_ready   = !out_valid || out_ready;
    assign s1_load_ok = !s1_valid || s2_ready;

    wta_rr_arb u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (s1_load_ok && !rst),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    assign accept   = |req_ready;
    assign gnt_data = req_data[DATA_W*int'(gnt_idx) +: DATA_W];

    // equal nibbles resolve to the upper nibble
    always_comb begin
        s2_d    = '0;
        s2_d.id = s1_id;
        if (s1_data[DATA_W-1:NIB_W] >= s1_data[NIB_W-1:0]) begin
            s2_d.data  = {s1_data[DATA_W-1:NIB_W], {NIB_W{1'b0}}};
            s2_d.upper = 1'b1;
        end else begin
            s2_d.data  = {{NIB_W{1'b0}}, s1_data[NIB_W-1:0]};
            s2_d.upper = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= gnt_data;
            s1_id    <= gnt_idx;
        end else if (s1_valid && s2_ready) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s2_q      <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign out_data  = s2_q.data;
    assign out_id    = s2_q.id;
    assign out_upper = s2_q.upper;
    assign busy      = s1_valid || out_valid;

endmodule
